// File: rtl/led_drv_pkg.sv
// led_drv_pkg: register map, CTRL bit layout and default sizes shared by the LED PWM driver.
package led_drv_pkg;
  localparam int N_LEDS_DEF = 10;
  localparam int PWM_BITS_DEF = 8;
  localparam int PRESC_W_DEF = 16;
  localparam int BHALF_W = 16;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DUTY = 2'd1;
  localparam logic [1:0] ADDR_PRESC = 2'd2;
  localparam logic [1:0] ADDR_BHALF = 2'd3;
  localparam int CTRL_PWM_EN = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_INVERT = 2;
  localparam int CTRL_PHASE = 8;
  typedef struct packed {
    logic invert;
    logic blink_en;
    logic pwm_en;
  } ctrl_t;
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler and free-running PWM counter; clr restarts both from zero.
module led_pwm_timebase
  import led_drv_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PRESC_W-1:0]  presc,
  input  logic                clr,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_end
);
  logic [PRESC_W-1:0] presc_cnt;
  assign tick = presc_cnt == presc;
  assign period_end = tick & (&pwm_cnt);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      pwm_cnt <= tick ? pwm_cnt + 1'b1 : pwm_cnt;
    end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: applies PWM brightness, blink and inversion to the PIO LED word; Avalon-MM configured.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int N_LEDS = N_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out
);
  ctrl_t ctrl;
  logic [PWM_BITS-1:0] duty, duty_sh, pwm_cnt;
  logic [PRESC_W-1:0] presc;
  logic [BHALF_W-1:0] bhalf, blink_cnt;
  logic blink_phase, blink_off, pwm_on, tick, period_end, wr, unused;
  assign wr = chipselect & ~write_n;
  assign unused = ^{writedata, tick};
  led_pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESC_W(PRESC_W)) u_tb (
    .clk(clk),
    .reset_n(reset_n),
    .presc(presc),
    .clr(wr && address == ADDR_PRESC),
    .tick(tick),
    .pwm_cnt(pwm_cnt),
    .period_end(period_end)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl <= '0;
      duty <= '0;
      presc <= '0;
      bhalf <= '0;
    end else if (wr) begin
      if (address == ADDR_CTRL) ctrl <= ctrl_t'(writedata[2:0]);
      if (address == ADDR_DUTY) duty <= writedata[PWM_BITS-1:0];
      if (address == ADDR_PRESC) presc <= writedata[PRESC_W-1:0];
      if (address == ADDR_BHALF) bhalf <= writedata[BHALF_W-1:0];
    end
  always_comb
    readdata = address == ADDR_CTRL  ? {23'd0, blink_phase, 5'd0, ctrl} :
               address == ADDR_DUTY  ? 32'(duty) :
               address == ADDR_PRESC ? 32'(presc) : 32'(bhalf);
  // duty_sh samples the old DUTY on the boundary edge, so a coinciding write waits a full period
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) duty_sh <= '0;
    else if (!ctrl.pwm_en || period_end) duty_sh <= duty;
  assign blink_off = ~ctrl.blink_en | (bhalf == '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_phase <= 1'b1;
    end else if (blink_off) begin
      blink_cnt <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      blink_cnt <= blink_cnt == bhalf - 1'b1 ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_cnt == bhalf - 1'b1 ? ~blink_phase : blink_phase;
    end
  assign pwm_on = ~ctrl.pwm_en | (pwm_cnt < duty_sh);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) led_out <= '0;
    else led_out <= (led_in & {N_LEDS{pwm_on & blink_phase}}) ^ {N_LEDS{ctrl.invert}};
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: vector table, directed PWM/blink/reset sequences and random traffic vs a cycle model.
module tb_led_pwm_driver;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [9:0] led_in = 0, led_out;
  int n_chk = 0, n_fail = 0;

  led_pwm_driver dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_in(led_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // reference model: prescaler phase and PWM position derived from cycles elapsed since last clear
  logic [2:0] m_ctrl;
  logic [7:0] m_duty, m_dsh;
  logic [15:0] m_presc, m_bhalf, m_bc;
  logic m_ph;
  logic [9:0] m_led;
  int m_since, m_ticks;

  task automatic model_reset();
    m_ctrl = 0; m_duty = 0; m_dsh = 0; m_presc = 0; m_bhalf = 0; m_bc = 0;
    m_ph = 1; m_led = 0; m_since = 0; m_ticks = 0;
  endtask

  function automatic logic [31:0] mrd(input logic [1:0] a);
    return a == 0 ? {23'd0, m_ph, 5'd0, m_ctrl} : a == 1 ? {24'd0, m_duty} :
           a == 2 ? {16'd0, m_presc} : {16'd0, m_bhalf};
  endfunction

  task automatic model_step();
    bit wr, tk, pe, on;
    int pos;
    if (!reset_n) begin model_reset(); return; end
    wr = chipselect && !write_n;
    tk = (m_since % (int'(m_presc) + 1)) == int'(m_presc);
    pos = m_ticks % 256;
    pe = tk && pos == 255;
    on = !m_ctrl[0] || pos < int'(m_dsh);
    m_led = (led_in & {10{on & m_ph}}) ^ {10{m_ctrl[2]}};
    if (!m_ctrl[1] || m_bhalf == 0) begin m_bc = 0; m_ph = 1; end
    else if (pe) begin
      if (m_bc == m_bhalf - 16'd1) begin m_bc = 0; m_ph = !m_ph; end
      else m_bc = m_bc + 16'd1;
    end
    if (!m_ctrl[0] || pe) m_dsh = m_duty;
    if (wr && address == 2) begin m_since = 0; m_ticks = 0; end
    else begin m_since++; m_ticks += int'(tk); end
    if (wr && address == 0) m_ctrl = writedata[2:0];
    if (wr && address == 1) m_duty = writedata[7:0];
    if (wr && address == 2) m_presc = writedata[15:0];
    if (wr && address == 3) m_bhalf = writedata[15:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("led_model", {22'd0, led_out}, {22'd0, m_led});
    chk("rdata_model", readdata, mrd(address));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    step();
    chipselect = 0; write_n = 1;
  endtask

  typedef struct {
    bit wr;
    logic [1:0] addr;
    logic [31:0] wd;
    logic [9:0] li;
    logic [9:0] el;
    logic [31:0] er;
  } vec_t;
  vec_t vt[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi[3];
    model_reset();
    led_in = 10'h2A5;
    repeat (3) step();
    chk("led_in_reset", {22'd0, led_out}, 32'd0);
    reset_n = 1;

    vt[0] = '{0, 0, 0,            10'h2A5, 10'h2A5, 32'h100};
    vt[1] = '{1, 1, 32'h1AB,      10'h155, 10'h155, 32'hAB};
    vt[2] = '{1, 2, 32'h12345,    10'h0AA, 10'h0AA, 32'h2345};
    vt[3] = '{1, 3, 32'hFFFF0007, 10'h3FF, 10'h3FF, 32'h7};
    vt[4] = '{1, 0, 32'hFFFFFF04, 10'h000, 10'h000, 32'h104};
    vt[5] = '{0, 0, 0,            10'h0F0, 10'h30F, 32'h104};
    vt[6] = '{1, 0, 32'h2,        10'h3FF, 10'h000, 32'h102};
    vt[7] = '{0, 0, 0,            10'h123, 10'h123, 32'h102};
    vt[8] = '{1, 0, 32'h0,        10'h2A5, 10'h2A5, 32'h100};
    foreach (vt[i]) begin
      chipselect = vt[i].wr; write_n = !vt[i].wr; address = vt[i].addr;
      writedata = vt[i].wd; led_in = vt[i].li;
      step();
      chk($sformatf("vec%0d_led", i), {22'd0, led_out}, {22'd0, vt[i].el});
      chk($sformatf("vec%0d_rd", i), readdata, vt[i].er);
    end
    chipselect = 0; write_n = 1;

    // duty 64, then 192 written exactly on the period boundary
    bus_write(1, 64);
    bus_write(0, 1);
    led_in = 10'h3FF;
    bus_write(2, 0);
    hi = '{0, 0, 0};
    for (int k = 1; k <= 768; k++) begin
      if (k == 256) begin chipselect = 1; write_n = 0; address = 1; writedata = 192; end
      step();
      chipselect = 0; write_n = 1;
      chk("pwm_wave", {22'd0, led_out}, ((k - 1) % 256) < (k <= 512 ? 64 : 192) ? 32'h3FF : 32'h0);
      if (led_out == 10'h3FF) hi[(k - 1) / 256]++;
    end
    chk("high_p0", hi[0], 64);
    chk("high_p1", hi[1], 64);
    chk("high_p2", hi[2], 192);

    bus_write(1, 255);
    bus_write(3, 2);
    bus_write(2, 0);
    bus_write(0, 3);
    for (int k = 2; k <= 2100; k++) begin
      step();
      chk("blink_phase", {31'd0, readdata[8]}, {31'd0, 1'b1 ^ 1'((k / 512) & 1)});
    end

    led_in = 0;
    bus_write(0, 4);
    step();
    chk("invert_off", {22'd0, led_out}, 32'h3FF);
    bus_write(1, 0);
    bus_write(0, 5);
    led_in = 10'h3FF;
    for (int k = 0; k < 300; k++) begin
      step();
      chk("duty0_inv", {22'd0, led_out}, 32'h3FF);
    end

    for (int k = 0; k < 4000; k++) begin
      led_in = 10'($urandom);
      address = 2'($urandom);
      chipselect = 1'($urandom);
      write_n = ($urandom_range(0, 3) != 0);
      case (address)
        0: writedata = {$urandom_range(0, 65535), 13'd0, 3'($urandom)};
        1: writedata = $urandom;
        2: writedata = {$urandom_range(0, 65535), 16'($urandom_range(0, 3))};
        default: writedata = {$urandom_range(0, 65535), 16'($urandom_range(0, 3))};
      endcase
      step();
    end
    chipselect = 0; write_n = 1;

    bus_write(2, 3);
    bus_write(1, 100);
    led_in = 0;
    bus_write(0, 5);
    address = 1;
    repeat (37) step();
    chk("pre_reset_led", {22'd0, led_out}, 32'h3FF);
    #3 reset_n = 0;
    #1;
    chk("async_rst_led", {22'd0, led_out}, 32'd0);
    chk("async_rst_duty", readdata, 32'd0);
    model_reset();
    repeat (3) step();
    reset_n = 1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      chk($sformatf("post_rst_reg%0d", a), readdata, a == 0 ? 32'h100 : 32'h0);
    end
    led_in = 10'h2A5;
    step();
    chk("post_rst_pass", {22'd0, led_out}, 32'h2A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
